// File: rtl/uart_cmd_wrapper.sv
// UART host link: 8N1 bytes in -> 16-bit commands (high byte first), 8-bit responses out.
// Optional stop-bit checking with resync of byte pairing when UART_FRAME_CHK_EN is defined.
module uart_cmd_wrapper #(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {WAIT_H, WAIT_L, READY} cmd_state_t;
  typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

  // RX synchronizer plus one history flop for falling-edge detection
  logic rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= RX;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  assign rx_fall = rx_prev_reg & ~rx_sync_reg;

  rx_state_t   rx_state_reg, rx_state_next;
  logic [11:0] rx_baud_reg, rx_baud_next;
  logic [3:0]  rx_bit_reg, rx_bit_next;
  logic [7:0]  rx_shift_reg, rx_shift_next;
  logic        byte_rdy;
  logic        frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_reg <= RX_IDLE;
      rx_baud_reg  <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_baud_reg  <= rx_baud_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_baud_next  = rx_baud_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    byte_rdy      = 1'b0;
    frame_err     = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_next = RX_START;
          rx_baud_next  = '0;
        end
      end
      RX_START: begin
        if (rx_baud_reg == HALF_LAST) begin
          rx_baud_next  = '0;
          rx_bit_next   = '0;
          rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
        end else begin
          rx_baud_next = rx_baud_reg + 12'd1;
        end
      end
      RX_DATA: begin
        if (rx_baud_reg == BAUD_LAST) begin
          rx_baud_next  = '0;
          rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
          rx_bit_next   = rx_bit_reg + 4'd1;
          if (rx_bit_reg == 4'd7) rx_state_next = RX_STOP;
        end else begin
          rx_baud_next = rx_baud_reg + 12'd1;
        end
      end
      RX_STOP: begin
        if (rx_baud_reg == BAUD_LAST) begin
          rx_baud_next  = '0;
          rx_state_next = RX_IDLE;
`ifdef UART_FRAME_CHK_EN
          if (rx_sync_reg) byte_rdy  = 1'b1;
          else             frame_err = 1'b1;
`else
          byte_rdy = 1'b1;
`endif
        end else begin
          rx_baud_next = rx_baud_reg + 12'd1;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // Byte pairing into commands
  cmd_state_t  cmd_state_reg, cmd_state_next;
  logic [15:0] cmd_next;
  logic        cmd_rdy_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_state_reg <= WAIT_H;
      cmd           <= '0;
      cmd_rdy       <= 1'b0;
    end else begin
      cmd_state_reg <= cmd_state_next;
      cmd           <= cmd_next;
      cmd_rdy       <= cmd_rdy_next;
    end
  end

  always_comb begin
    cmd_state_next = cmd_state_reg;
    cmd_next       = cmd;
    cmd_rdy_next   = cmd_rdy;
    case (cmd_state_reg)
      WAIT_H: begin
        if (byte_rdy) begin
          cmd_next       = {rx_shift_reg, cmd[7:0]};
          cmd_state_next = WAIT_L;
        end
      end
      WAIT_L: begin
        if (byte_rdy) begin
          cmd_next       = {cmd[15:8], rx_shift_reg};
          cmd_rdy_next   = 1'b1;
          cmd_state_next = READY;
        end else if (frame_err) begin
          cmd_state_next = WAIT_H;
        end
      end
      READY: begin
        // bytes arriving here are dropped, even alongside a clear
        if (clr_cmd_rdy) begin
          cmd_rdy_next   = 1'b0;
          cmd_state_next = WAIT_H;
        end
      end
      default: cmd_state_next = WAIT_H;
    endcase
  end

  // TX path; TX and resp_sent are one register stage behind the shifter
  tx_state_t   tx_state_reg, tx_state_next;
  logic [9:0]  tx_shift_reg, tx_shift_next;
  logic [11:0] tx_baud_reg, tx_baud_next;
  logic [3:0]  tx_bit_reg, tx_bit_next;
  logic        tx_done_reg, tx_done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_reg <= TX_IDLE;
      tx_shift_reg <= '1;
      tx_baud_reg  <= '0;
      tx_bit_reg   <= '0;
      tx_done_reg  <= 1'b0;
      TX           <= 1'b1;
      resp_sent    <= 1'b0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_shift_reg <= tx_shift_next;
      tx_baud_reg  <= tx_baud_next;
      tx_bit_reg   <= tx_bit_next;
      tx_done_reg  <= tx_done_next;
      TX           <= tx_shift_reg[0];
      resp_sent    <= tx_done_reg;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_shift_next = tx_shift_reg;
    tx_baud_next  = tx_baud_reg;
    tx_bit_next   = tx_bit_reg;
    tx_done_next  = tx_done_reg;
    case (tx_state_reg)
      TX_IDLE: begin
        if (send_resp) begin
          tx_shift_next = {1'b1, resp, 1'b0};
          tx_baud_next  = '0;
          tx_bit_next   = '0;
          tx_done_next  = 1'b0;
          tx_state_next = TX_XMIT;
        end
      end
      TX_XMIT: begin
        if (tx_baud_reg == BAUD_LAST) begin
          tx_baud_next  = '0;
          tx_shift_next = {1'b1, tx_shift_reg[9:1]};
          tx_bit_next   = tx_bit_reg + 4'd1;
          if (tx_bit_reg == 4'd9) begin
            tx_done_next  = 1'b1;
            tx_state_next = TX_IDLE;
          end
        end else begin
          tx_baud_next = tx_baud_reg + 12'd1;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

endmodule
